// File: rtl/param_counter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// param_counter_if : control/status bundle for param_counter      rev 1.0
// PARAM_COUNTER_OVF_STICKY_EN adds the ovf_sticky status line.
// ---------------------------------------------------------------------------
interface param_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             start;
  logic             one_shot;
  logic             dir;
  logic             saturate;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             done;

`ifdef PARAM_COUNTER_OVF_STICKY_EN
  logic             ovf_sticky;

  modport master (
    output en, start, one_shot, dir, saturate, load, load_val,
    input  count, busy, tc, done, ovf_sticky
  );

  modport slave (
    input  en, start, one_shot, dir, saturate, load, load_val,
    output count, busy, tc, done, ovf_sticky
  );
`else
  modport master (
    output en, start, one_shot, dir, saturate, load, load_val,
    input  count, busy, tc, done
  );

  modport slave (
    input  en, start, one_shot, dir, saturate, load, load_val,
    output count, busy, tc, done
  );
`endif
endinterface
`default_nettype wire

// File: rtl/param_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// param_counter : up/down modulo counter with load, wrap/saturate, one-shot  rev 1.0
// PARAM_COUNTER_OVF_STICKY_EN adds a sticky overflow flag set on every wrap.
// ---------------------------------------------------------------------------
module param_counter #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 256,
  parameter int RST_VAL = 0
) (
  input  logic           clk,
  input  logic           rst,
  param_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] term;
  logic             busy_q;
  logic             tc_q;
  logic             done_q;
  logic             at_term;
  logic             step;
  logic             start_ok;

  always_comb begin
    term     = bus.dir ? MAX_VAL : '0;
    at_term  = (count_q == term);
    step     = (state == RUN) && bus.en && !bus.load;
    start_ok = (state == IDLE) && bus.start;

    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (step && at_term && bus.one_shot) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Load overrides stepping; out-of-range load values clamp to the top.
    count_nxt = count_q;
    if (bus.load) begin
      count_nxt = ({1'b0, bus.load_val} >= MOD_EXT) ? MAX_VAL : bus.load_val;
    end else if (step) begin
      if (!at_term) begin
        count_nxt = bus.dir ? count_q + ONE : count_q - ONE;
      end else if (!bus.one_shot && !bus.saturate) begin
        count_nxt = bus.dir ? '0 : MAX_VAL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count_q <= RST_CNT;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      count_q <= count_nxt;
      busy_q  <= (state_nxt == RUN);
      tc_q    <= step && at_term;
      done_q  <= (state_nxt == DONE);
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.tc    = tc_q;
  assign bus.done  = done_q;

`ifdef PARAM_COUNTER_OVF_STICKY_EN
  logic wrap_step;
  logic ovf_q;

  assign wrap_step = step && at_term && !bus.one_shot && !bus.saturate;

  // Clearing events take precedence over a wrap in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (bus.load || start_ok) begin
      ovf_q <= 1'b0;
    end else if (wrap_step) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.ovf_sticky = ovf_q;
`endif

endmodule
`default_nettype wire
